// File: rtl/ddr_line_fetcher_if.sv
// ----------------------------------------------------------------------------
// ddr_line_fetcher_if
// Bundles the memory command port, the memory read-data FIFO port and the
// pixel-word output stream of ddr_line_fetcher.
//   cmd_en/cmd_instr/cmd_bl/cmd_byte_addr : read command, qualified by !cmd_full
//   rd_data/rd_empty/rd_en                : first-word-fall-through read FIFO
//   out_data/out_valid/out_ready          : output word stream
// Modports: master = fetcher side, slave = memory controller / stream sink.
//
// Handshakes: a word moves on the stream in every cycle where out_valid and
// out_ready are both 1; out_valid never waits for out_ready.  rd_en is the
// same transfer seen from the FIFO side and pops the word shown on rd_data.
// A command is taken in every cycle where cmd_en is 1, and cmd_en is only
// raised while cmd_full is 0.
// ----------------------------------------------------------------------------
interface ddr_line_fetcher_if #(
    parameter int ADDR_W = 30
);
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [ADDR_W-1:0] cmd_byte_addr;
    logic              cmd_full;
    logic [31:0]       rd_data;
    logic              rd_empty;
    logic              rd_en;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en, out_data, out_valid,
        input  cmd_full, rd_data, rd_empty, out_ready
    );

    modport slave (
        input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en, out_data, out_valid,
        output cmd_full, rd_data, rd_empty, out_ready
    );
endinterface

// File: rtl/ddr_line_fetcher.sv
// ----------------------------------------------------------------------------
// ddr_line_fetcher
// Fetches a frame from DDR one line at a time.  A frame is armed by
// frame_start; each line_req pulse reads one line as a series of read bursts
// (at most MAX_BURST words each) and streams the words out.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   mem_calib_done      : asynchronous calibration-complete level
//   frame_base          : byte address of line 0 (sampled on frame_start)
//   line_words          : words per line (sampled on frame_start)
//   num_lines           : lines per frame (sampled on frame_start)
//   frame_start         : arm a new frame (pulse)
//   line_req            : fetch next line (pulse)
//   bus                 : memory command / read FIFO / output stream
//   busy                : line transfer in progress
//   frame_done          : one-cycle pulse at the end of a frame
//   req_err             : sticky flag for ignored requests
//   dbg_state_o         : current FSM state
// ----------------------------------------------------------------------------
module ddr_line_fetcher #(
    parameter int ADDR_W    = 30,
    parameter int MAX_BURST = 64,
    parameter int LINE_W    = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_calib_done,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [LINE_W-1:0] line_words,
    input  logic [LINE_W-1:0] num_lines,
    input  logic              frame_start,
    input  logic              line_req,
    ddr_line_fetcher_if.master bus,
    output logic              busy,
    output logic              frame_done,
    output logic              req_err,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        WAIT_CAL = 3'd0,
        IDLE     = 3'd1,
        ARMED    = 3'd2,
        CMD      = 3'd3,
        DATA     = 3'd4,
        LINE_END = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              cal_meta_q, cal_sync_q;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [LINE_W-1:0] line_words_q, line_words_d;
    logic [LINE_W-1:0] num_lines_q, num_lines_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [LINE_W-1:0] word_off_q, word_off_d;
    logic [LINE_W-1:0] remaining_q, remaining_d;
    // 7 bits so that a full 64-word burst is representable.
    logic [6:0]        burst_q, burst_d;
    logic [6:0]        beat_q, beat_d;
    logic              frame_done_q, frame_done_d;
    logic              req_err_q, req_err_d;

    logic [6:0]        burst_c;
    logic [ADDR_W-1:0] cmd_addr_c;
    logic              valid_c;
    logic              fire_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cal_meta_q   <= 1'b0;
            cal_sync_q   <= 1'b0;
            state_q      <= WAIT_CAL;
            line_addr_q  <= '0;
            line_words_q <= '0;
            num_lines_q  <= '0;
            line_cnt_q   <= '0;
            word_off_q   <= '0;
            remaining_q  <= '0;
            burst_q      <= '0;
            beat_q       <= '0;
            frame_done_q <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            cal_meta_q   <= mem_calib_done;
            cal_sync_q   <= cal_meta_q;
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            line_words_q <= line_words_d;
            num_lines_q  <= num_lines_d;
            line_cnt_q   <= line_cnt_d;
            word_off_q   <= word_off_d;
            remaining_q  <= remaining_d;
            burst_q      <= burst_d;
            beat_q       <= beat_d;
            frame_done_q <= frame_done_d;
            req_err_q    <= req_err_d;
        end
    end

    // Burst size and command address are pure functions of the registered
    // line position, so they stay frozen while the command queue is full.
    always_comb begin
        burst_c    = (32'(remaining_q) >= MAX_BURST) ? 7'(MAX_BURST) : 7'(remaining_q);
        cmd_addr_c = line_addr_q + ADDR_W'({word_off_q, 2'b00});
    end

    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        line_words_d = line_words_q;
        num_lines_d  = num_lines_q;
        line_cnt_d   = line_cnt_q;
        word_off_d   = word_off_q;
        remaining_d  = remaining_q;
        burst_d      = burst_q;
        beat_d       = beat_q;
        frame_done_d = 1'b0;
        req_err_d    = req_err_q
                     | (frame_start && (state_q != IDLE))
                     | (line_req && (state_q != ARMED));
        valid_c      = 1'b0;
        fire_c       = 1'b0;

        bus.cmd_en        = 1'b0;
        bus.cmd_instr     = 3'b000;
        bus.cmd_bl        = 6'd0;
        bus.cmd_byte_addr = '0;
        bus.out_data      = 32'd0;
        bus.out_valid     = 1'b0;
        bus.rd_en         = 1'b0;

        case (state_q)
            WAIT_CAL: begin
                if (cal_sync_q) state_d = IDLE;
            end
            IDLE: begin
                if (frame_start) begin
                    line_addr_d  = frame_base;
                    line_words_d = line_words;
                    num_lines_d  = num_lines;
                    line_cnt_d   = '0;
                    word_off_d   = '0;
                    // An empty frame completes immediately without any traffic.
                    if ((line_words == '0) || (num_lines == '0)) frame_done_d = 1'b1;
                    else                                         state_d      = ARMED;
                end
            end
            ARMED: begin
                if (line_req) begin
                    remaining_d = line_words_q;
                    word_off_d  = '0;
                    state_d     = CMD;
                end
            end
            CMD: begin
                bus.cmd_instr     = 3'b001;
                bus.cmd_bl        = 6'(burst_c - 7'd1);
                bus.cmd_byte_addr = cmd_addr_c;
                if (!bus.cmd_full) begin
                    bus.cmd_en = 1'b1;
                    burst_d    = burst_c;
                    beat_d     = 7'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                valid_c       = !bus.rd_empty;
                fire_c        = valid_c && bus.out_ready;
                bus.out_data  = bus.rd_data;
                bus.out_valid = valid_c;
                bus.rd_en     = fire_c;
                if (fire_c) begin
                    beat_d = beat_q + 7'd1;
                    if (beat_q + 7'd1 == burst_q) begin
                        word_off_d  = word_off_q + LINE_W'(burst_q);
                        remaining_d = remaining_q - LINE_W'(burst_q);
                        state_d     = (remaining_d != '0) ? CMD : LINE_END;
                    end
                end
            end
            LINE_END: begin
                line_addr_d = line_addr_q + ADDR_W'({line_words_q, 2'b00});
                line_cnt_d  = line_cnt_q + 1'b1;
                word_off_d  = '0;
                if (line_cnt_d == num_lines_q) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d      = ARMED;
                end
            end
            default: state_d = WAIT_CAL;
        endcase
    end

    assign busy        = (state_q == CMD) || (state_q == DATA) || (state_q == LINE_END);
    assign frame_done  = frame_done_q;
    assign req_err     = req_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ddr_line_fetcher.sv
`timescale 1ns/1ps
module tb_ddr_line_fetcher;

    localparam int ADDR_W = 30;
    localparam logic [2:0] S_WAIT_CAL = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_CMD      = 3'd3;
    localparam logic [2:0] S_DATA     = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              mem_calib_done = 1'b0;
    logic [ADDR_W-1:0] frame_base = '0;
    logic [10:0]       line_words = '0;
    logic [10:0]       num_lines = '0;
    logic              frame_start = 1'b0;
    logic              line_req = 1'b0;
    logic              busy, frame_done, req_err;
    logic [2:0]        dbg_state;

    ddr_line_fetcher_if #(.ADDR_W(ADDR_W)) bus ();

    ddr_line_fetcher #(.ADDR_W(ADDR_W), .MAX_BURST(64), .LINE_W(11)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_calib_done (mem_calib_done),
        .frame_base     (frame_base),
        .line_words     (line_words),
        .num_lines      (num_lines),
        .frame_start    (frame_start),
        .line_req       (line_req),
        .bus            (bus),
        .busy           (busy),
        .frame_done     (frame_done),
        .req_err        (req_err),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    logic [38:0] got_cmd_q[$];
    logic [38:0] exp_cmd_q[$];
    int fd_cnt = 0;
    int wd_cnt = 0;
    bit tog_en = 1'b0;
    int flush_gen = 0;
    logic              snap_cmd = 1'b0;
    logic              snap_rd = 1'b0;
    logic [5:0]        snap_bl = '0;
    logic [ADDR_W-1:0] snap_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return {2'b00, a} ^ 32'h5A00_0000;
    endfunction

    function automatic logic [38:0] pack_cmd(input logic [2:0] i, input logic [5:0] bl,
                                             input logic [ADDR_W-1:0] a);
        return {i, bl, a};
    endfunction

    // Monitor: mid-cycle snapshot of what the next rising edge will commit.
    always @(negedge clk) begin
        snap_cmd  = bus.cmd_en;
        snap_rd   = bus.rd_en;
        snap_bl   = bus.cmd_bl;
        snap_addr = bus.cmd_byte_addr;
        if (bus.cmd_en) got_cmd_q.push_back(pack_cmd(bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr));
        if (frame_done) fd_cnt++;
        if (bus.rd_en) begin
            wd_cnt++;
            check("rd_en_needs_ready", bus.out_ready, 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_data: got 0x%0h, expected no word", bus.out_data);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // Memory model: each command queues its burst into the read FIFO.
    initial begin : mem_model
        int flush_seen;
        flush_seen   = 0;
        bus.rd_empty = 1'b1;
        bus.rd_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (flush_gen != flush_seen) begin
                flush_seen = flush_gen;
                mem_q.delete();
            end else begin
                if (snap_rd && mem_q.size() > 0) void'(mem_q.pop_front());
                if (snap_cmd)
                    for (int i = 0; i <= int'(snap_bl); i++)
                        mem_q.push_back(mem_word(snap_addr + ADDR_W'(4 * i)));
            end
            bus.rd_empty = (mem_q.size() == 0);
            bus.rd_data  = (mem_q.size() == 0) ? 32'h0 : mem_q[0];
        end
    end

    // Sink: ready always high, or toggling every cycle when tog_en is set.
    initial begin : sink
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = tog_en ? ~bus.out_ready : 1'b1;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_lr();
        tick();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (dbg_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, dbg_state, s);
    endtask

    task automatic build_expect(input logic [ADDR_W-1:0] base, input int lw, input int nl);
        logic [ADDR_W-1:0] laddr, a;
        int rem, off, b;
        exp_cmd_q.delete();
        laddr = base;
        for (int l = 0; l < nl; l++) begin
            rem = lw;
            off = 0;
            while (rem > 0) begin
                b = (rem > 64) ? 64 : rem;
                a = laddr + ADDR_W'(off * 4);
                exp_cmd_q.push_back(pack_cmd(3'b001, 6'(b - 1), a));
                for (int w = 0; w < b; w++) exp_q.push_back(mem_word(a + ADDR_W'(w * 4)));
                rem -= b;
                off += b;
            end
            laddr = laddr + ADDR_W'(lw * 4);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                lw;
        int                nl;
        bit                tog;
        int                exp_cmds;
        int                exp_words;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int fd0;
        int n;
        got_cmd_q.delete();
        wd_cnt = 0;
        fd0 = fd_cnt;
        build_expect(v.base, v.lw, v.nl);
        tog_en      = v.tog;
        frame_base  = v.base;
        line_words  = 11'(v.lw);
        num_lines   = 11'(v.nl);
        pulse_fs();
        if (v.lw == 0 || v.nl == 0) begin
            @(negedge clk);
            check("zero_frame_done_next", frame_done, 1);
            tick();
            tick();
        end else begin
            for (int l = 0; l < v.nl; l++) begin
                wait_state(S_ARMED, 3000, "line_armed");
                pulse_lr();
            end
            wait_state(S_IDLE, 3000, "frame_idle");
        end
        tog_en = 1'b0;
        @(negedge clk);
        check("cmd_count", got_cmd_q.size(), v.exp_cmds);
        check("word_count", wd_cnt, v.exp_words);
        check("frame_done_count", fd_cnt - fd0, 1);
        check("exp_q_drained", exp_q.size(), 0);
        check("end_busy", busy, 0);
        check("end_state", dbg_state, S_IDLE);
        n = (got_cmd_q.size() < exp_cmd_q.size()) ? got_cmd_q.size() : exp_cmd_q.size();
        for (int i = 0; i < n; i++) check("cmd", got_cmd_q[i], exp_cmd_q[i]);
    endtask

    // ---------------- test ----------------
    vec_t vecs[7];
    logic [38:0] req034[6];

    initial begin : main
        int n;
        int fd0;
        vecs[0] = '{30'h0000_0100, 160, 2, 1'b0, 6, 320};
        vecs[1] = '{30'h0000_1000,  64, 1, 1'b0, 1,  64};
        vecs[2] = '{30'h3FFF_FF00,  65, 2, 1'b1, 4, 130};
        vecs[3] = '{30'h0000_2000,   1, 3, 1'b0, 3,   3};
        vecs[4] = '{30'h0000_0040,   0, 5, 1'b0, 0,   0};
        vecs[5] = '{30'h0000_0040,   7, 0, 1'b0, 0,   0};
        vecs[6] = '{30'h0000_0800, 128, 1, 1'b1, 2, 128};
        req034[0] = pack_cmd(3'b001, 6'd63, 30'h100);
        req034[1] = pack_cmd(3'b001, 6'd63, 30'h200);
        req034[2] = pack_cmd(3'b001, 6'd31, 30'h300);
        req034[3] = pack_cmd(3'b001, 6'd63, 30'h380);
        req034[4] = pack_cmd(3'b001, 6'd63, 30'h480);
        req034[5] = pack_cmd(3'b001, 6'd31, 30'h580);
        bus.cmd_full = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_en", bus.cmd_en, 0);
        check("rst_cmd_instr", bus.cmd_instr, 0);
        check("rst_cmd_bl", bus.cmd_bl, 0);
        check("rst_cmd_addr", bus.cmd_byte_addr, 0);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_req_err", req_err, 0);
        check("rst_state", dbg_state, S_WAIT_CAL);

        // Calibration wait and synchroniser latency
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("hold_wait_cal", dbg_state, S_WAIT_CAL);
        tick();
        mem_calib_done = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (dbg_state != S_IDLE && n < 10);
        checks++;
        if (dbg_state != S_IDLE || n < 2 || n > 3) begin
            errors++;
            $display("FAIL cal_latency: got %0d clocks (state %0d), expected 2..3 clocks to IDLE", n, dbg_state);
        end
        check("no_cmd_before_idle", got_cmd_q.size(), 0);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i]);
            if (i == 0) begin
                for (int k = 0; k < 6; k++)
                    if (k < got_cmd_q.size()) check("req034_cmd", got_cmd_q[k], req034[k]);
            end
        end

        // Command queue full: hold with stable address, then one command
        got_cmd_q.delete();
        wd_cnt = 0;
        fd0 = fd_cnt;
        build_expect(30'h4000, 8, 1);
        frame_base = 30'h4000;
        line_words = 11'd8;
        num_lines  = 11'd1;
        pulse_fs();
        wait_state(S_ARMED, 10, "stall_armed");
        bus.cmd_full = 1'b1;
        pulse_lr();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_cmd_en", bus.cmd_en, 0);
            check("stall_addr", bus.cmd_byte_addr, 30'h4000);
            check("stall_state", dbg_state, S_CMD);
        end
        tick();
        bus.cmd_full = 1'b0;
        wait_state(S_IDLE, 200, "stall_idle");
        @(negedge clk);
        check("stall_cmd_count", got_cmd_q.size(), 1);
        if (got_cmd_q.size() > 0) check("stall_cmd", got_cmd_q[0], pack_cmd(3'b001, 6'd7, 30'h4000));
        check("stall_words", wd_cnt, 8);
        check("stall_frame_done", fd_cnt - fd0, 1);

        // Ignored requests
        check("req_err_clear", req_err, 0);
        got_cmd_q.delete();
        wd_cnt = 0;
        fd0 = fd_cnt;
        build_expect(30'h8000, 100, 1);
        frame_base = 30'h8000;
        line_words = 11'd100;
        num_lines  = 11'd1;
        pulse_fs();
        wait_state(S_ARMED, 10, "err_armed");
        frame_base = 30'h9000;
        line_words = 11'd5;
        pulse_fs();
        @(negedge clk);
        check("fs_in_armed_err", req_err, 1);
        check("fs_in_armed_state", dbg_state, S_ARMED);
        pulse_lr();
        wait_state(S_DATA, 10, "err_data");
        pulse_lr();
        wait_state(S_IDLE, 500, "err_idle");
        @(negedge clk);
        check("err_cmd_count", got_cmd_q.size(), 2);
        if (got_cmd_q.size() > 1) begin
            check("err_cmd0", got_cmd_q[0], pack_cmd(3'b001, 6'd63, 30'h8000));
            check("err_cmd1", got_cmd_q[1], pack_cmd(3'b001, 6'd35, 30'h8100));
        end
        check("err_words", wd_cnt, 100);
        check("err_frame_done", fd_cnt - fd0, 1);
        check("err_sticky", req_err, 1);

        // Reset in the middle of a burst
        got_cmd_q.delete();
        build_expect(30'h10000, 64, 1);
        frame_base = 30'h10000;
        line_words = 11'd64;
        num_lines  = 11'd1;
        pulse_fs();
        wait_state(S_ARMED, 10, "mid_armed");
        pulse_lr();
        wait_state(S_DATA, 10, "mid_data");
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_cmd_en", bus.cmd_en, 0);
        check("mid_rst_cmd_instr", bus.cmd_instr, 0);
        check("mid_rst_cmd_bl", bus.cmd_bl, 0);
        check("mid_rst_cmd_addr", bus.cmd_byte_addr, 0);
        check("mid_rst_rd_en", bus.rd_en, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_req_err", req_err, 0);
        check("mid_rst_state", dbg_state, S_WAIT_CAL);
        exp_q.delete();
        flush_gen++;
        tick();
        tick();
        reset_n = 1'b1;
        wait_state(S_IDLE, 10, "recover_idle");
        check("recover_req_err", req_err, 0);

        // Simultaneous frame_start and line_req in IDLE
        got_cmd_q.delete();
        wd_cnt = 0;
        fd0 = fd_cnt;
        build_expect(30'h20000, 3, 1);
        frame_base = 30'h20000;
        line_words = 11'd3;
        num_lines  = 11'd1;
        tick();
        frame_start = 1'b1;
        line_req    = 1'b1;
        tick();
        frame_start = 1'b0;
        line_req    = 1'b0;
        @(negedge clk);
        check("both_state", dbg_state, S_ARMED);
        check("both_req_err", req_err, 1);
        pulse_lr();
        wait_state(S_IDLE, 100, "both_idle");
        @(negedge clk);
        check("both_cmd_count", got_cmd_q.size(), 1);
        if (got_cmd_q.size() > 0) check("both_cmd", got_cmd_q[0], pack_cmd(3'b001, 6'd2, 30'h20000));
        check("both_words", wd_cnt, 3);
        check("both_frame_done", fd_cnt - fd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
